core_logic_prog: RTL and testbench
==================================

Name: core_logic_prog

Overview:
- Parametrised, table-programmable successor to the TAP core-logic FSM.
- A Mealy state machine with STATE_W-bit state and IN_W-bit input X. The next state comes from a writable transition table instead of a hard-coded case list.
- Adds a self-timed BIST run mode that steps the FSM for a programmed number of cycles and compresses the visited states into a MISR signature.
- Sits behind the TAP instruction decode (RUNBIST/INTEST selects) and feeds Y to the boundary-scan capture path.

Parameters:
- STATE_W, 4, state / Y width.
- IN_W, 4, input X width.
- CNT_W, 16, BIST cycle counter width.
- SIG_W, 16, signature width (SIG_W >= STATE_W).
- SIG_POLY, 16'h1021, MISR feedback polynomial (SIG_W bits).
- SIG_SEED, 16'hFFFF, MISR seed loaded at BIST start and on reset.

Ports:
- clk  in  1  single clock; all logic on posedge.
- RESET_SM  in  1  synchronous active-high reset.
- TLR  in  1  Test-Logic-Reset; synchronous, same effect as RESET_SM.
- ENABLE  in  1  functional step enable (RUNBIST_SELECT | INTEST_SELECT).
- ASSIGN_STATE  in  1  load state <= X[STATE_W-1:0] instead of a table step.
- X  in  IN_W  FSM input.
- TBL_WE  in  1  transition table write strobe.
- TBL_ADDR  in  STATE_W+IN_W  write address, {state, X}.
- TBL_WDATA  in  STATE_W+1  {valid, next_state}.
- BIST_START  in  1  single-cycle pulse; starts a BIST run.
- BIST_CYCLES  in  CNT_W  number of FSM steps in the run; sampled on the start cycle.
- Y  out  STATE_W  current state.
- BIST_BUSY  out  1  run in progress.
- BIST_DONE  out  1  sticky run-complete flag.
- SIGNATURE  out  SIG_W  MISR contents.

Behaviour:
- Reset (RESET_SM | TLR, sampled at posedge):
  - state=0, BIST_BUSY=0, BIST_DONE=0, SIGNATURE=SIG_SEED.
  - Counter cleared.
  - All 2^(STATE_W+IN_W) table valid bits cleared; next-state data is not reset.
  - Reset has priority over every other input, including mid-run: the run aborts and DONE is not set.
- Table:
  - Entry at {state, X} holds {valid, next}.
  - Write takes effect on the clock edge.
  - A step reading the same address in the same cycle uses the old entry (read-before-write).
  - Writes are allowed in any mode.
- Step condition: step = ENABLE | BIST_BUSY. Priority, highest first:
  1. Reset.
  2. step & ASSIGN_STATE: state <= X[STATE_W-1:0]. If IN_W < STATE_W, X is zero-extended.
  3. step & valid[{state, X}]: state <= next[{state, X}].
  4. Otherwise state holds. An invalid entry means hold, matching the "no match" behaviour of the fixed FSM.
- Zero-latency output: Y = state register; the next state is visible one cycle after the step edge.
- BIST start (BIST_START & !BIST_BUSY & !reset):
  - Counter <= BIST_CYCLES, SIGNATURE <= SIG_SEED, BIST_DONE <= 0.
  - BIST_BUSY <= 1 if BIST_CYCLES != 0.
  - If BIST_CYCLES == 0: BUSY stays 0 and BIST_DONE <= 1 on that edge; no steps are taken and SIGNATURE = SIG_SEED.
  - State does not change on the start edge unless ENABLE causes a functional step.
- BIST_START while BUSY is ignored.
- While BUSY, each cycle:
  - FSM steps per the priority above, regardless of ENABLE.
  - SIGNATURE <= (SIGNATURE << 1) ^ (SIGNATURE[SIG_W-1] ? SIG_POLY : 0) ^ zero_ext(next_state), where next_state is the value written to state on that edge (the hold value if no transition).
  - Counter decrements.
  - On the edge where the counter goes 1 -> 0: BUSY <= 0, BIST_DONE <= 1.
  - Exactly BIST_CYCLES steps and MISR updates occur.
- BIST_DONE stays high until the next accepted start or reset.
- SIGNATURE is held when not BUSY.
- Counter has no wrap: BIST_CYCLES = 2^CNT_W-1 runs the full count.

Test Plan:
- Reset/hold:
  - Assert RESET_SM 1 cycle -> Y=0, BUSY=0, DONE=0, SIGNATURE=16'hFFFF.
  - ENABLE=1 with an empty table and X=4'h5 for 5 cycles -> Y stays 0.
- Table step:
  - Write {0,X=0}->{1,4'h2} and {2,X=4'hB}->{1,4'h1}.
  - ENABLE=1, X=0 then X=B -> Y=2, then Y=1.
  - X=7 (invalid entry) -> Y holds 1.
  - ENABLE=0 -> no change.
- Priority:
  - ENABLE=1, ASSIGN_STATE=1, X=4'hC with a valid entry present -> Y=C.
  - Assert TLR in the same cycle -> Y=0.
  - Write to {C,X} in the same cycle as a step from C -> step uses the old entry.
- BIST single step:
  - Table {0,X=0}->2, X=0, BIST_CYCLES=1, pulse BIST_START, ENABLE=0.
  - -> BUSY for 1 cycle; Y=2, SIGNATURE=16'hEFDD, DONE=1 sticky.
  - A second START clears DONE.
- BIST zero/abort:
  - BIST_CYCLES=0 -> DONE=1 next edge, BUSY never set, SIGNATURE=FFFF.
  - BIST_CYCLES=10, RESET_SM at cycle 4 -> BUSY=0, DONE=0, Y=0.
  - START pulsed mid-run is ignored; the run ends after exactly 10 steps.
- Parameter sweep:
  - STATE_W=6, IN_W=3, SIG_W=32 (SIG_POLY=32'h04C11DB7).
  - Random table with ASSIGN_STATE=0 and a random X sequence checked against a reference model.
  - Y and SIGNATURE match after a 1000-cycle BIST run.

Source files
------------

// File: rtl/core_logic_prog.sv
// Table-programmable Mealy FSM with a self-timed BIST run mode that compresses
// every visited state into a MISR signature.
module core_logic_prog #(
  parameter int unsigned      STATE_W  = 4,
  parameter int unsigned      IN_W     = 4,
  parameter int unsigned      CNT_W    = 16,
  parameter int unsigned      SIG_W    = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = 16'h1021,
  parameter logic [SIG_W-1:0] SIG_SEED = 16'hFFFF
) (
  input  logic                     clk,
  input  logic                     RESET_SM,
  input  logic                     TLR,
  input  logic                     ENABLE,
  input  logic                     ASSIGN_STATE,
  input  logic [IN_W-1:0]          X,
  input  logic                     TBL_WE,
  input  logic [STATE_W+IN_W-1:0]  TBL_ADDR,
  input  logic [STATE_W:0]         TBL_WDATA,
  input  logic                     BIST_START,
  input  logic [CNT_W-1:0]         BIST_CYCLES,
  output logic [STATE_W-1:0]       Y,
  output logic                     BIST_BUSY,
  output logic                     BIST_DONE,
  output logic [SIG_W-1:0]         SIGNATURE
);

  localparam int unsigned AW    = STATE_W + IN_W;
  localparam int unsigned DEPTH = 1 << AW;

  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0]   sig,
                                                 input logic [STATE_W-1:0] st);
    logic [SIG_W-1:0] ext;
    ext              = '0;
    ext[STATE_W-1:0] = st;
    misr_step = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? SIG_POLY : '0) ^ ext;
  endfunction

  logic [DEPTH-1:0]   valid_q;
  logic [STATE_W-1:0] next_mem [DEPTH];

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [SIG_W-1:0]   sig_q, sig_d;

  logic               reset_s;
  logic               step_s;
  logic [AW-1:0]      rd_addr_s;
  logic [STATE_W-1:0] x_ext_s;

  assign reset_s   = RESET_SM | TLR;
  assign step_s    = ENABLE | busy_q;
  assign rd_addr_s = {state_q, X};

  // ASSIGN_STATE loads X, zero-extended or truncated to the state width
  if (IN_W >= STATE_W) begin : g_x_trunc
    assign x_ext_s = X[STATE_W-1:0];
  end else begin : g_x_zext
    assign x_ext_s = {{(STATE_W-IN_W){1'b0}}, X};
  end

  // Next-state data is deliberately not reset; only the valid bits are
  always_ff @(posedge clk) begin
    if (TBL_WE) begin
      next_mem[TBL_ADDR] <= TBL_WDATA[STATE_W-1:0];
    end
  end

  // State, BIST control and table valid bits; reset beats everything
  always_ff @(posedge clk) begin
    if (reset_s) begin
      valid_q <= '0;
      state_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sig_q   <= SIG_SEED;
    end else begin
      if (TBL_WE) begin
        valid_q[TBL_ADDR] <= TBL_WDATA[STATE_W];
      end
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sig_q   <= sig_d;
    end
  end

  // Step priority and BIST sequencing; the table read sees the pre-write entry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    sig_d   = sig_q;

    if (step_s && ASSIGN_STATE) begin
      state_d = x_ext_s;
    end else if (step_s && valid_q[rd_addr_s]) begin
      state_d = next_mem[rd_addr_s];
    end else begin
      state_d = state_q;
    end

    if (busy_q) begin
      cnt_d = cnt_q - CNT_W'(1);
      sig_d = misr_step(sig_q, state_d);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
        done_d = done_q;
      end
    end else if (BIST_START) begin
      cnt_d  = BIST_CYCLES;
      sig_d  = SIG_SEED;
      busy_d = (BIST_CYCLES != '0);
      done_d = (BIST_CYCLES == '0);
    end else begin
      busy_d = busy_q;
      done_d = done_q;
    end
  end

  assign Y         = state_q;
  assign BIST_BUSY = busy_q;
  assign BIST_DONE = done_q;
  assign SIGNATURE = sig_q;

endmodule

// File: tb/tb_core_logic_prog.sv
// Self-checking bench: directed scenarios on the default configuration plus
// randomized table/BIST runs compared against a behavioural model.
module tb_core_logic_prog;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default configuration DUT
  logic        rst = 1'b0, tlr = 1'b0, en = 1'b0, asg = 1'b0, we = 1'b0, bstart = 1'b0;
  logic [3:0]  x = 4'h0;
  logic [7:0]  waddr = 8'h00;
  logic [4:0]  wdata = 5'h00;
  logic [15:0] bcyc = 16'h0000;
  logic [3:0]  y;
  logic        busy, done;
  logic [15:0] sig;

  core_logic_prog dut (
    .clk(clk), .RESET_SM(rst), .TLR(tlr), .ENABLE(en), .ASSIGN_STATE(asg), .X(x),
    .TBL_WE(we), .TBL_ADDR(waddr), .TBL_WDATA(wdata), .BIST_START(bstart),
    .BIST_CYCLES(bcyc), .Y(y), .BIST_BUSY(busy), .BIST_DONE(done), .SIGNATURE(sig)
  );

  // swept configuration DUT
  logic        rst_b = 1'b0, tlr_b = 1'b0, en_b = 1'b0, asg_b = 1'b0, we_b = 1'b0, bstart_b = 1'b0;
  logic [2:0]  x_b = 3'h0;
  logic [8:0]  waddr_b = 9'h000;
  logic [6:0]  wdata_b = 7'h00;
  logic [15:0] bcyc_b = 16'h0000;
  logic [5:0]  y_b;
  logic        busy_b, done_b;
  logic [31:0] sig_b;

  core_logic_prog #(
    .STATE_W(6), .IN_W(3), .CNT_W(16), .SIG_W(32),
    .SIG_POLY(32'h04C11DB7), .SIG_SEED(32'hFFFF_FFFF)
  ) dut_b (
    .clk(clk), .RESET_SM(rst_b), .TLR(tlr_b), .ENABLE(en_b), .ASSIGN_STATE(asg_b), .X(x_b),
    .TBL_WE(we_b), .TBL_ADDR(waddr_b), .TBL_WDATA(wdata_b), .BIST_START(bstart_b),
    .BIST_CYCLES(bcyc_b), .Y(y_b), .BIST_BUSY(busy_b), .BIST_DONE(done_b), .SIGNATURE(sig_b)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] misr16(input logic [15:0] s, input logic [3:0] st);
    return (s << 1) ^ (s[15] ? 16'h1021 : 16'h0000) ^ {12'h000, st};
  endfunction

  function automatic logic [31:0] misr32(input logic [31:0] s, input logic [5:0] st);
    return (s << 1) ^ (s[31] ? 32'h04C11DB7 : 32'h0000_0000) ^ {26'h0, st};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [3:0] s, input logic [3:0] xi,
                             input logic v, input logic [3:0] n);
    we = 1'b1; waddr = {s, xi}; wdata = {v, n};
    tick();
    we = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    pulse_reset();
    checks++; if (y !== 4'h0) begin errors++; $display("FAIL reset_y got %h exp 0", y); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (sig !== 16'hFFFF) begin errors++; $display("FAIL reset_sig got %h exp FFFF", sig); end
    en = 1'b1; x = 4'h5;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (y !== 4'h0) begin errors++; $display("FAIL empty_hold got %h exp 0", y); end
    end
    en = 1'b0;
  endtask

  task automatic test_table_step();
    write_entry(4'h0, 4'h0, 1'b1, 4'h2);
    write_entry(4'h2, 4'hB, 1'b1, 4'h1);
    write_entry(4'h1, 4'h3, 1'b1, 4'h5);
    en = 1'b1; x = 4'h0; tick();
    checks++; if (y !== 4'h2) begin errors++; $display("FAIL step_x0 got %h exp 2", y); end
    x = 4'hB; tick();
    checks++; if (y !== 4'h1) begin errors++; $display("FAIL step_xB got %h exp 1", y); end
    x = 4'h7; tick();
    checks++; if (y !== 4'h1) begin errors++; $display("FAIL invalid_hold got %h exp 1", y); end
    en = 1'b0; x = 4'h3; tick();
    checks++; if (y !== 4'h1) begin errors++; $display("FAIL enable_low got %h exp 1", y); end
    en = 1'b1; tick(); en = 1'b0;
    checks++; if (y !== 4'h5) begin errors++; $display("FAIL enable_high got %h exp 5", y); end
  endtask

  task automatic test_priority();
    write_entry(4'h5, 4'hC, 1'b1, 4'h3);
    en = 1'b1; asg = 1'b1; x = 4'hC; tick();
    checks++; if (y !== 4'hC) begin errors++; $display("FAIL assign_over_table got %h exp C", y); end
    tlr = 1'b1; x = 4'h5; tick(); tlr = 1'b0; asg = 1'b0;
    checks++; if (y !== 4'h0) begin errors++; $display("FAIL tlr_priority got %h exp 0", y); end
    x = 4'h0; tick();
    checks++; if (y !== 4'h0) begin errors++; $display("FAIL valid_cleared got %h exp 0", y); end
    en = 1'b0;
    write_entry(4'hC, 4'h1, 1'b1, 4'h4);
    en = 1'b1; asg = 1'b1; x = 4'hC; tick(); asg = 1'b0;
    x = 4'h1; we = 1'b1; waddr = 8'hC1; wdata = 5'h17; tick(); we = 1'b0;
    checks++; if (y !== 4'h4) begin errors++; $display("FAIL read_before_write got %h exp 4", y); end
    asg = 1'b1; x = 4'hC; tick(); asg = 1'b0;
    x = 4'h1; tick(); en = 1'b0;
    checks++; if (y !== 4'h7) begin errors++; $display("FAIL write_landed got %h exp 7", y); end
  endtask

  task automatic test_bist_single();
    pulse_reset();
    write_entry(4'h0, 4'h0, 1'b1, 4'h2);
    x = 4'h0; en = 1'b0; bcyc = 16'd1; bstart = 1'b1; tick(); bstart = 1'b0;
    checks++; if (busy !== 1'b1 || y !== 4'h0) begin errors++; $display("FAIL bist1_start busy=%b y=%h exp busy=1 y=0", busy, y); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL bist1_end busy=%b done=%b exp 0 1", busy, done); end
    checks++; if (y !== 4'h2) begin errors++; $display("FAIL bist1_y got %h exp 2", y); end
    checks++; if (sig !== 16'hEFDD) begin errors++; $display("FAIL bist1_sig got %h exp EFDD", sig); end
    tick();
    checks++; if (done !== 1'b1 || sig !== 16'hEFDD) begin errors++; $display("FAIL bist1_sticky done=%b sig=%h exp 1 EFDD", done, sig); end
    bcyc = 16'd2; bstart = 1'b1; tick(); bstart = 1'b0;
    checks++; if (done !== 1'b0 || busy !== 1'b1 || sig !== 16'hFFFF) begin errors++; $display("FAIL bist2_start done=%b busy=%b sig=%h exp 0 1 FFFF", done, busy, sig); end
    tick(); tick();
    checks++; if (done !== 1'b1 || busy !== 1'b0 || sig !== 16'hCF99) begin errors++; $display("FAIL bist2_end done=%b busy=%b sig=%h exp 1 0 CF99", done, busy, sig); end
  endtask

  task automatic test_bist_zero_abort();
    logic [3:0]  e_st;
    logic [15:0] e_sig;
    int n;
    bcyc = 16'd0; bstart = 1'b1; tick(); bstart = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || sig !== 16'hFFFF) begin errors++; $display("FAIL bist0 done=%b busy=%b sig=%h exp 1 0 FFFF", done, busy, sig); end
    tick();
    checks++; if (busy !== 1'b0 || y !== 4'h2) begin errors++; $display("FAIL bist0_nostep busy=%b y=%h exp 0 2", busy, y); end
    write_entry(4'h2, 4'h0, 1'b1, 4'h3);
    write_entry(4'h3, 4'h0, 1'b1, 4'h2);
    x = 4'h0; bcyc = 16'd10; bstart = 1'b1; tick(); bstart = 1'b0;
    repeat (4) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_midrun busy=%b exp 1", busy); end
    pulse_reset();
    checks++; if (busy !== 1'b0 || done !== 1'b0 || y !== 4'h0 || sig !== 16'hFFFF) begin errors++; $display("FAIL abort busy=%b done=%b y=%h sig=%h exp 0 0 0 FFFF", busy, done, y, sig); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_stays busy=%b done=%b exp 0 0", busy, done); end
    write_entry(4'h0, 4'h0, 1'b1, 4'h1);
    write_entry(4'h1, 4'h0, 1'b1, 4'h0);
    x = 4'h0; bcyc = 16'd10; bstart = 1'b1; tick(); bstart = 1'b0;
    e_st = 4'h0; e_sig = 16'hFFFF; n = 0;
    while (busy === 1'b1 && n < 50) begin
      bstart = (n == 3); bcyc = 16'd5;
      e_st = (e_st == 4'h0) ? 4'h1 : 4'h0;
      e_sig = misr16(e_sig, e_st);
      tick(); n++;
    end
    bstart = 1'b0;
    checks++; if (n != 10) begin errors++; $display("FAIL midrun_start_len got %0d exp 10", n); end
    checks++; if (y !== e_st || sig !== e_sig || done !== 1'b1) begin errors++; $display("FAIL midrun_result y=%h sig=%h done=%b exp %h %h 1", y, sig, done, e_st, e_sig); end
  endtask

  task automatic test_random_step();
    bit         mv[256];
    logic [3:0] mn[256];
    logic [3:0] m_st;
    int idx;
    pulse_reset();
    m_st = 4'h0;
    for (int i = 0; i < 256; i++) begin
      mv[i] = ($urandom_range(0, 3) != 0);
      mn[i] = 4'($urandom);
      write_entry(4'(i >> 4), 4'(i), mv[i], mn[i]);
    end
    for (int k = 0; k < 200; k++) begin
      en = 1'($urandom); asg = ($urandom_range(0, 7) == 0); x = 4'($urandom);
      we = ($urandom_range(0, 3) == 0); waddr = 8'($urandom); wdata = 5'($urandom);
      idx = {m_st, x};
      if (en && asg) m_st = x;
      else if (en && mv[idx]) m_st = mn[idx];
      if (we) begin mv[waddr] = wdata[4]; mn[waddr] = wdata[3:0]; end
      tick();
      checks++; if (y !== m_st) begin errors++; $display("FAIL random_step cyc %0d got %h exp %h", k, y, m_st); end
    end
    en = 1'b0; asg = 1'b0; we = 1'b0;
  endtask

  task automatic test_param_sweep();
    bit          mv[512];
    logic [5:0]  mn[512];
    logic [5:0]  m_st;
    logic [31:0] m_sig;
    int idx;
    rst_b = 1'b1; tick(); rst_b = 1'b0;
    checks++; if (y_b !== 6'h00 || sig_b !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sweep_reset y=%h sig=%h", y_b, sig_b); end
    for (int i = 0; i < 512; i++) begin
      mv[i] = ($urandom_range(0, 3) != 0);
      mn[i] = 6'($urandom);
      we_b = 1'b1; waddr_b = 9'(i); wdata_b = {mv[i], mn[i]};
      tick();
    end
    we_b = 1'b0;
    m_st = 6'h00; m_sig = 32'hFFFF_FFFF;
    bcyc_b = 16'd1000; bstart_b = 1'b1; tick(); bstart_b = 1'b0;
    checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL sweep_start busy=%b exp 1", busy_b); end
    for (int k = 0; k < 1000; k++) begin
      x_b = 3'($urandom);
      idx = {m_st, x_b};
      if (mv[idx]) m_st = mn[idx];
      m_sig = misr32(m_sig, m_st);
      tick();
      checks++; if (y_b !== m_st) begin errors++; $display("FAIL sweep_y cyc %0d got %h exp %h", k, y_b, m_st); end
    end
    checks++; if (busy_b !== 1'b0 || done_b !== 1'b1) begin errors++; $display("FAIL sweep_end busy=%b done=%b exp 0 1", busy_b, done_b); end
    checks++; if (sig_b !== m_sig) begin errors++; $display("FAIL sweep_sig got %h exp %h", sig_b, m_sig); end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    tick();
    test_reset();
    test_table_step();
    test_priority();
    test_bist_single();
    test_bist_zero_abort();
    test_random_step();
    test_param_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
